// File: rtl/traffic_pkg.sv
// Shared types for the intersection traffic-mode controller.
// Mode select encodings and the sequencer state enum.
package traffic_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        CLEAR  = 2'd1,
        PED    = 2'd2,
        EMG    = 2'd3
    } state_e;

    localparam logic [3:0] MODE_DAY   = 4'b0001;
    localparam logic [3:0] MODE_NIGHT = 4'b0010;
    localparam logic [3:0] MODE_PED   = 4'b0100;
    localparam logic [3:0] MODE_EMG   = 4'b1000;
    localparam logic [3:0] MODE_NONE  = 4'b0000;

    // Two's-complement trick isolates the lowest set bit.
    function automatic logic [7:0] lowest_set(input logic [7:0] v);
        return v & (~v + 8'd1);
    endfunction

endpackage

// File: rtl/phase_down_counter.sv
// Loadable down-counter that saturates at zero.
// One instance times every phase of the sequencer.
module phase_down_counter #(
    parameter int           W       = 7,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= RST_VAL;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/traffic_mode_sequencer.sv
// Mode sequencer: day/night, pedestrian and emergency arbitration
// with a mandatory all-red clearance between every mode change.
module traffic_mode_sequencer
    import traffic_pkg::*;
#(
    parameter int CNT_W      = 7,
    parameter int CLEAR_TIME = 3,
    parameter int MIN_HOLD   = 10,
    parameter int PED_TIME   = 20,
    parameter int EMG_MAX    = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dayNight,
    input  logic             pedReq,
    input  logic             emgReq,
    input  logic [7:0]       emgLaneIn,
    output logic [3:0]       modeOneHot,
    output logic             allRed,
    output logic [7:0]       emgLane,
    output logic             pedAck,
    output logic             emgAck,
    output logic [CNT_W-1:0] phaseCount
);

    localparam int LIM = 1 << CNT_W;

    if (CLEAR_TIME < 1 || MIN_HOLD < 1 || PED_TIME < 1 || EMG_MAX < 1 ||
        CLEAR_TIME > LIM || MIN_HOLD > LIM ||
        PED_TIME > LIM || EMG_MAX > LIM) begin : g_param_err
        $error("traffic_mode_sequencer: timing parameter out of range");
    end

    state_e           state_q, state_d;
    state_e           target_q, target_d;
    logic             dayMode_q, dayMode_d;
    logic             pedPending_q, pedPending_d;
    logic             emgLock_q, emgLock_d;
    logic [7:0]       emgLane_q, emgLane_d;
    logic             pedAck_q, emgAck_q, allRed_q;
    logic             emgValid, cnt_zero, cnt_load;
    logic [CNT_W-1:0] cnt_val, cnt_q;

    assign emgValid = emgReq & ~emgLock_q & (emgLaneIn != '0);

    phase_down_counter #(
        .W       (CNT_W),
        .RST_VAL (CNT_W'(CLEAR_TIME - 1))
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .dec_i      (1'b1),
        .count_o    (cnt_q),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= CLEAR;
            target_q     <= NORMAL;
            dayMode_q    <= 1'b0;
            pedPending_q <= 1'b0;
            emgLock_q    <= 1'b0;
            emgLane_q    <= '0;
            pedAck_q     <= 1'b0;
            emgAck_q     <= 1'b0;
            allRed_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            target_q     <= target_d;
            dayMode_q    <= dayMode_d;
            pedPending_q <= pedPending_d;
            emgLock_q    <= emgLock_d;
            emgLane_q    <= emgLane_d;
            pedAck_q     <= (state_d == PED) && (state_q != PED);
            emgAck_q     <= (state_d == EMG) && (state_q != EMG);
            allRed_q     <= (state_d == CLEAR);
        end
    end

    always_comb begin
        state_d      = state_q;
        target_d     = target_q;
        dayMode_d    = dayMode_q;
        emgLane_d    = emgLane_q;
        emgLock_d    = emgReq ? emgLock_q : 1'b0;
        pedPending_d = pedPending_q | pedReq;
        unique case (state_q)
            NORMAL: begin
                if (emgValid) begin
                    state_d   = CLEAR;
                    target_d  = EMG;
                    emgLane_d = lowest_set(emgLaneIn);
                end else if (dayNight != dayMode_q) begin
                    state_d  = CLEAR;
                    target_d = NORMAL;
                end else if (pedPending_q && cnt_zero) begin
                    state_d  = CLEAR;
                    target_d = PED;
                end
            end
            CLEAR: begin
                // Target may be upgraded or reverted without restarting the count.
                if (emgValid && target_q != EMG) begin
                    target_d  = EMG;
                    emgLane_d = lowest_set(emgLaneIn);
                end else if (target_q == EMG && !emgReq) begin
                    target_d = NORMAL;
                end
                if (cnt_zero) state_d = target_d;
            end
            PED: begin
                if (emgValid) begin
                    state_d   = CLEAR;
                    target_d  = EMG;
                    emgLane_d = lowest_set(emgLaneIn);
                end else if (cnt_zero) begin
                    state_d  = CLEAR;
                    target_d = NORMAL;
                end
            end
            EMG: begin
                if (!emgReq) begin
                    state_d  = CLEAR;
                    target_d = NORMAL;
                end else if (cnt_zero) begin
                    state_d   = CLEAR;
                    target_d  = NORMAL;
                    emgLock_d = 1'b1;
                end
            end
        endcase
        if (state_d == NORMAL && state_q != NORMAL) dayMode_d = dayNight;
        if (state_d == PED && state_q != PED) pedPending_d = 1'b0;
    end

    assign cnt_load = (state_d != state_q);

    always_comb begin
        cnt_val = '0;
        unique case (state_d)
            NORMAL: cnt_val = CNT_W'(MIN_HOLD - 1);
            CLEAR:  cnt_val = CNT_W'(CLEAR_TIME - 1);
            PED:    cnt_val = CNT_W'(PED_TIME - 1);
            EMG:    cnt_val = CNT_W'(EMG_MAX - 1);
        endcase
    end

    always_comb begin
        modeOneHot = MODE_NONE;
        unique case (1'b1)
            (state_q == NORMAL) &&  dayMode_q: modeOneHot = MODE_DAY;
            (state_q == NORMAL) && !dayMode_q: modeOneHot = MODE_NIGHT;
            (state_q == PED):                  modeOneHot = MODE_PED;
            (state_q == EMG):                  modeOneHot = MODE_EMG;
            (state_q == CLEAR):                modeOneHot = MODE_NONE;
        endcase
    end

    assign allRed     = allRed_q;
    assign emgLane    = emgLane_q;
    assign pedAck     = pedAck_q;
    assign emgAck     = emgAck_q;
    assign phaseCount = cnt_q;

endmodule

// File: tb/tb_traffic_mode_sequencer.sv
// Directed bench for traffic_mode_sequencer: a table of hold-and-check
// rows plus hand-written reset sequences.
module tb_traffic_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       dayNight, pedReq, emgReq;
    logic [7:0] emgLaneIn;
    logic [3:0] modeOneHot;
    logic       allRed, pedAck, emgAck;
    logic [7:0] emgLane;
    logic [6:0] phaseCount;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic       dn;
        logic       ped;
        logic       emg;
        logic [7:0] lin;
        logic [3:0] mode;
        logic       ar;
        logic       pa;
        logic       ea;
        logic [6:0] pc;
        logic [7:0] lane;
    } vec_t;

    vec_t tbl[$];

    traffic_mode_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .dayNight   (dayNight),
        .pedReq     (pedReq),
        .emgReq     (emgReq),
        .emgLaneIn  (emgLaneIn),
        .modeOneHot (modeOneHot),
        .allRed     (allRed),
        .emgLane    (emgLane),
        .pedAck     (pedAck),
        .emgAck     (emgAck),
        .phaseCount (phaseCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d got %0h want %0h", nm, row, act, exp);
        end
    endtask

    task automatic chk_all(input int row, input logic [3:0] mode,
                           input logic ar, input logic pa, input logic ea,
                           input logic [6:0] pc, input logic [7:0] lane);
        chk("mode", row, 32'(modeOneHot), 32'(mode));
        chk("allRed", row, 32'(allRed), 32'(ar));
        chk("pedAck", row, 32'(pedAck), 32'(pa));
        chk("emgAck", row, 32'(emgAck), 32'(ea));
        chk("phaseCount", row, 32'(phaseCount), 32'(pc));
        chk("emgLane", row, 32'(emgLane), 32'(lane));
    endtask

    initial begin
        // cyc dn ped emg lin | mode ar pa ea pc lane
        tbl.push_back('{2,  1'b1,1'b0,1'b0,8'h00, 4'h0,1'b1,1'b0,1'b0,7'd0, 8'h00});
        tbl.push_back('{1,  1'b1,1'b0,1'b0,8'h00, 4'h1,1'b0,1'b0,1'b0,7'd9, 8'h00});
        tbl.push_back('{1,  1'b1,1'b0,1'b0,8'h00, 4'h1,1'b0,1'b0,1'b0,7'd8, 8'h00});
        tbl.push_back('{1,  1'b1,1'b1,1'b0,8'h00, 4'h1,1'b0,1'b0,1'b0,7'd7, 8'h00});
        tbl.push_back('{6,  1'b1,1'b0,1'b0,8'h00, 4'h1,1'b0,1'b0,1'b0,7'd1, 8'h00});
        tbl.push_back('{1,  1'b1,1'b0,1'b0,8'h00, 4'h1,1'b0,1'b0,1'b0,7'd0, 8'h00});
        tbl.push_back('{1,  1'b1,1'b0,1'b0,8'h00, 4'h0,1'b1,1'b0,1'b0,7'd2, 8'h00});
        tbl.push_back('{2,  1'b1,1'b0,1'b0,8'h00, 4'h0,1'b1,1'b0,1'b0,7'd0, 8'h00});
        tbl.push_back('{1,  1'b1,1'b0,1'b0,8'h00, 4'h4,1'b0,1'b1,1'b0,7'd19,8'h00});
        tbl.push_back('{1,  1'b1,1'b0,1'b0,8'h00, 4'h4,1'b0,1'b0,1'b0,7'd18,8'h00});
        tbl.push_back('{18, 1'b1,1'b0,1'b0,8'h00, 4'h4,1'b0,1'b0,1'b0,7'd0, 8'h00});
        tbl.push_back('{1,  1'b1,1'b0,1'b0,8'h00, 4'h0,1'b1,1'b0,1'b0,7'd2, 8'h00});
        tbl.push_back('{3,  1'b1,1'b0,1'b0,8'h00, 4'h1,1'b0,1'b0,1'b0,7'd9, 8'h00});
        tbl.push_back('{1,  1'b1,1'b0,1'b1,8'h00, 4'h1,1'b0,1'b0,1'b0,7'd8, 8'h00});
        tbl.push_back('{1,  1'b1,1'b1,1'b0,8'h00, 4'h1,1'b0,1'b0,1'b0,7'd7, 8'h00});
        tbl.push_back('{7,  1'b1,1'b0,1'b0,8'h00, 4'h1,1'b0,1'b0,1'b0,7'd0, 8'h00});
        tbl.push_back('{1,  1'b1,1'b0,1'b0,8'h00, 4'h0,1'b1,1'b0,1'b0,7'd2, 8'h00});
        tbl.push_back('{3,  1'b1,1'b0,1'b0,8'h00, 4'h4,1'b0,1'b1,1'b0,7'd19,8'h00});
        tbl.push_back('{2,  1'b1,1'b0,1'b0,8'h00, 4'h4,1'b0,1'b0,1'b0,7'd17,8'h00});
        tbl.push_back('{1,  1'b1,1'b0,1'b1,8'h24, 4'h0,1'b1,1'b0,1'b0,7'd2, 8'h04});
        tbl.push_back('{2,  1'b1,1'b0,1'b1,8'h24, 4'h0,1'b1,1'b0,1'b0,7'd0, 8'h04});
        tbl.push_back('{1,  1'b1,1'b0,1'b1,8'h24, 4'h8,1'b0,1'b0,1'b1,7'd59,8'h04});
        tbl.push_back('{1,  1'b1,1'b0,1'b1,8'h80, 4'h8,1'b0,1'b0,1'b0,7'd58,8'h04});
        tbl.push_back('{1,  1'b1,1'b0,1'b0,8'h80, 4'h0,1'b1,1'b0,1'b0,7'd2, 8'h04});
        tbl.push_back('{3,  1'b1,1'b0,1'b0,8'h80, 4'h1,1'b0,1'b0,1'b0,7'd9, 8'h04});
        tbl.push_back('{9,  1'b1,1'b0,1'b0,8'h80, 4'h1,1'b0,1'b0,1'b0,7'd0, 8'h04});
        tbl.push_back('{1,  1'b1,1'b0,1'b0,8'h80, 4'h1,1'b0,1'b0,1'b0,7'd0, 8'h04});
        tbl.push_back('{1,  1'b1,1'b0,1'b1,8'h01, 4'h0,1'b1,1'b0,1'b0,7'd2, 8'h01});
        tbl.push_back('{2,  1'b1,1'b0,1'b1,8'h01, 4'h0,1'b1,1'b0,1'b0,7'd0, 8'h01});
        tbl.push_back('{1,  1'b1,1'b0,1'b1,8'h01, 4'h8,1'b0,1'b0,1'b1,7'd59,8'h01});
        tbl.push_back('{59, 1'b1,1'b0,1'b1,8'h01, 4'h8,1'b0,1'b0,1'b0,7'd0, 8'h01});
        tbl.push_back('{1,  1'b1,1'b0,1'b1,8'h01, 4'h0,1'b1,1'b0,1'b0,7'd2, 8'h01});
        tbl.push_back('{3,  1'b1,1'b0,1'b1,8'h01, 4'h1,1'b0,1'b0,1'b0,7'd9, 8'h01});
        tbl.push_back('{33, 1'b1,1'b0,1'b1,8'h01, 4'h1,1'b0,1'b0,1'b0,7'd0, 8'h01});
        tbl.push_back('{1,  1'b1,1'b0,1'b0,8'h01, 4'h1,1'b0,1'b0,1'b0,7'd0, 8'h01});
        tbl.push_back('{1,  1'b1,1'b0,1'b1,8'h01, 4'h0,1'b1,1'b0,1'b0,7'd2, 8'h01});
        tbl.push_back('{2,  1'b1,1'b0,1'b0,8'h01, 4'h0,1'b1,1'b0,1'b0,7'd0, 8'h01});
        tbl.push_back('{1,  1'b1,1'b0,1'b0,8'h01, 4'h1,1'b0,1'b0,1'b0,7'd9, 8'h01});
        tbl.push_back('{1,  1'b0,1'b0,1'b0,8'h01, 4'h0,1'b1,1'b0,1'b0,7'd2, 8'h01});
        tbl.push_back('{1,  1'b0,1'b0,1'b1,8'h10, 4'h0,1'b1,1'b0,1'b0,7'd1, 8'h10});
        tbl.push_back('{1,  1'b0,1'b0,1'b0,8'h10, 4'h0,1'b1,1'b0,1'b0,7'd0, 8'h10});
        tbl.push_back('{1,  1'b0,1'b0,1'b0,8'h10, 4'h2,1'b0,1'b0,1'b0,7'd9, 8'h10});
        tbl.push_back('{1,  1'b0,1'b1,1'b1,8'h0C, 4'h0,1'b1,1'b0,1'b0,7'd2, 8'h04});
        tbl.push_back('{2,  1'b0,1'b0,1'b1,8'h0C, 4'h0,1'b1,1'b0,1'b0,7'd0, 8'h04});
        tbl.push_back('{1,  1'b0,1'b0,1'b1,8'h0C, 4'h8,1'b0,1'b0,1'b1,7'd59,8'h04});
        tbl.push_back('{1,  1'b0,1'b0,1'b0,8'h0C, 4'h0,1'b1,1'b0,1'b0,7'd2, 8'h04});
        tbl.push_back('{3,  1'b0,1'b0,1'b0,8'h0C, 4'h2,1'b0,1'b0,1'b0,7'd9, 8'h04});
        tbl.push_back('{9,  1'b0,1'b0,1'b0,8'h0C, 4'h2,1'b0,1'b0,1'b0,7'd0, 8'h04});
        tbl.push_back('{1,  1'b0,1'b0,1'b0,8'h0C, 4'h0,1'b1,1'b0,1'b0,7'd2, 8'h04});
        tbl.push_back('{3,  1'b0,1'b0,1'b0,8'h0C, 4'h4,1'b0,1'b1,1'b0,7'd19,8'h04});

        rst = 1'b0;
        dayNight = 1'b1;
        pedReq = 1'b0;
        emgReq = 1'b0;
        emgLaneIn = 8'h00;
        #12;
        rst = 1'b1;
        #1;
        chk_all(-1, 4'h0, 1'b1, 1'b0, 1'b0, 7'd2, 8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            dayNight  = tbl[i].dn;
            pedReq    = tbl[i].ped;
            emgReq    = tbl[i].emg;
            emgLaneIn = tbl[i].lin;
            repeat (tbl[i].cyc) @(posedge clk);
            #1;
            chk_all(i, tbl[i].mode, tbl[i].ar, tbl[i].pa, tbl[i].ea,
                    tbl[i].pc, tbl[i].lane);
        end

        // Preempt PED into EMG, then hit reset asynchronously mid-EMG.
        emgReq    = 1'b1;
        emgLaneIn = 8'h40;
        repeat (4) @(posedge clk);
        #1;
        chk_all(100, 4'h8, 1'b0, 1'b0, 1'b1, 7'd59, 8'h40);
        #2;
        rst = 1'b0;
        #1;
        chk_all(101, 4'h0, 1'b1, 1'b0, 1'b0, 7'd2, 8'h00);
        @(posedge clk);
        #1;
        chk_all(102, 4'h0, 1'b1, 1'b0, 1'b0, 7'd2, 8'h00);
        emgReq = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all(103, 4'h2, 1'b0, 1'b0, 1'b0, 7'd9, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_mode_sequencer.md
Name: traffic_mode_sequencer

Overview:
- Central controller for the intersection's traffic-mode datapath. It decides which mode (day, night, pedestrian, emergency) drives the output light mux and timer load.
- Arbitrates pedestrian and emergency requests against normal day/night operation.
- Inserts a mandatory all-red clearance interval between every mode change.
- Drives the one-hot mode select consumed by the light-output and load-time muxes, plus request acknowledges.

Parameters:
- CNT_W, 7, width of all phase counters and phaseCount.
- CLEAR_TIME, 3, all-red clearance length in clk cycles (1 s each); must be ≥1.
- MIN_HOLD, 10, minimum cycles normal mode runs before a pedestrian request may be served.
- PED_TIME, 20, pedestrian phase length in cycles.
- EMG_MAX, 60, maximum continuous emergency phase length in cycles.

Ports:
- clk, input, 1, 1 Hz system clock; all state changes on rising edge.
- rst, input, 1, asynchronous, active-low reset.
- dayNight, input, 1, 1 = day, 0 = night; already synchronous.
- pedReq, input, 1, pedestrian request; a pulse or level, sampled every cycle.
- emgReq, input, 1, emergency request level; held high by the requester while needed.
- emgLaneIn, input, 8, requested emergency lane, nominally one-hot.
- modeOneHot, output, 4, mode select: 0001 day, 0010 night, 0100 pedestrian, 1000 emergency, 0000 during clearance.
- allRed, output, 1, high during the clearance interval.
- emgLane, output, 8, latched one-hot lane for the emergency mode.
- pedAck, output, 1, one-cycle pulse on entry to PED.
- emgAck, output, 1, one-cycle pulse on entry to EMG.
- phaseCount, output, CNT_W, cycles remaining in the current timed phase.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=CLEAR, target=NORMAL, count=CLEAR_TIME-1.
  - allRed=1, modeOneHot=0000, emgLane=0, pedAck=emgAck=0.
  - pedPending=0, emgLock=0, phaseCount=CLEAR_TIME-1.
- States: NORMAL, CLEAR, PED, EMG. All outputs are registered except modeOneHot, which is decoded from the state register and, in NORMAL, from the registered dayMode.
- pedPending:
  - Set in any cycle where pedReq=1.
  - Cleared in the cycle PED is entered, the same edge pedAck pulses.
  - A request arriving during PED sets pedPending again; it is served on a later cycle.
- emgValid = emgReq & ~emgLock & (emgLaneIn≠0).
- Lane latch: when emgValid causes a transition toward EMG, emgLane is loaded with the lowest set bit of emgLaneIn. Non-one-hot input is reduced, not rejected.
- NORMAL:
  - Entry: dayMode<=dayNight, count<=MIN_HOLD-1; count decrements, saturating at 0.
  - Exit priority:
    1. emgValid → CLEAR, target EMG; ignores MIN_HOLD.
    2. dayNight≠dayMode → CLEAR, target NORMAL.
    3. pedPending & count==0 → CLEAR, target PED.
- CLEAR:
  - Lasts exactly CLEAR_TIME cycles; count goes CLEAR_TIME-1 down to 0, then the state moves to target.
  - emgValid mid-clear upgrades target to EMG and latches the lane; the count does not restart.
  - If target=EMG and emgReq drops before the end, target reverts to NORMAL.
- PED:
  - Lasts PED_TIME cycles, then CLEAR with target NORMAL.
  - emgValid preempts immediately → CLEAR, target EMG. The preempted pedestrian phase is not re-served unless a new pedReq arrives.
- EMG:
  - Stays while emgReq=1. emgLaneIn changes during EMG are ignored.
  - emgReq=0 → CLEAR, target NORMAL.
  - After EMG_MAX cycles → CLEAR, target NORMAL, and emgLock<=1.
  - emgLock clears on the first cycle emgReq=0, so a stuck requester cannot starve other modes.
- phaseCount mirrors the active down-counter in every state. In EMG it shows EMG_MAX-1 minus elapsed cycles.
- Simultaneous pedReq and emgReq: emergency wins; pedPending stays set and is served after emergency when the hold expires.
- All counters are CNT_W bits. Every parameter must be ≤ 2^CNT_W; an elaboration-time assertion checks this.

Decomposition:
- Shared package traffic_pkg:
  - state enum {NORMAL, CLEAR, PED, EMG}.
  - MODE_DAY=4'b0001, MODE_NIGHT=4'b0010, MODE_PED=4'b0100, MODE_EMG=4'b1000, MODE_NONE=4'b0000.
- Sub-module phase_down_counter (load, load value, decrement, saturate at zero, zero flag), instantiated once and shared by all states.

Test Plan:
- Reset release with dayNight=1: allRed=1 for 3 cycles, then modeOneHot=0001, phaseCount=9.
- pedReq pulse at cycle 2 of NORMAL: stays 0001 until hold expires (cycle 10), 3 cycles 0000/allRed, then 0100 with pedAck one cycle; after 20 cycles, clear, then back to 0001.
- emgReq=1, emgLaneIn=8'b0010_0100 during PED: next cycle CLEAR. After 3 cycles, modeOneHot=1000, emgLane=8'b0000_0100, emgAck pulses. emgReq=0 returns to normal via clear.
- emgReq held high for 100 cycles: EMG ends after exactly 60 cycles and normal resumes via clear. No re-entry to EMG until emgReq goes low for one cycle and rises again.
- dayNight 1→0 during NORMAL: clear, then 0010. emgReq pulse at clear cycle 1 that drops by cycle 2: target reverts to NORMAL, 0010, no emgAck.
- Assert rst=0 mid-EMG (asynchronous, between edges): outputs immediately allRed=1, modeOneHot=0000, emgLane=0.
